// File: rtl/sp_unit_pipe.sv
// Special-purpose unit: rotate, popcount, CLZ, reverse, min/max, CRC step.
// Results queue in an in-order writeback FIFO; CRC path built with SP_UNIT_CRC_EN.
module sp_unit_pipe #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter int          ID_W     = 3,
  parameter logic [31:0] CRC_POLY = 32'hEDB88320
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [2:0]      issue_fn3,
  input  logic [6:0]      issue_fn7,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  input  logic [ID_W-1:0] issue_id,
  input  logic            flush,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [XLEN-1:0] wb_rd,
  input  logic            wb_ack
);
  localparam int SW    = $clog2(XLEN);
  localparam int CNT_W = SW + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [XLEN-1:0] mem_rd [DEPTH];
  logic [ID_W-1:0] mem_id [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   count;

  logic            accept, push, pop, idle;
  logic [XLEN-1:0] op_res, push_rd;
  logic [ID_W-1:0] push_id;
  logic [SW-1:0]   sh;
  logic            lt;
  logic            unused_bits;

  function automatic logic [XLEN-1:0] f_pop(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + CNT_W'(v[i]);
    return XLEN'(n);
  endfunction

  function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_W'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (v[i]) n = CNT_W'(XLEN - 1 - i);
    return XLEN'(n);
  endfunction

  function automatic logic [XLEN-1:0] f_brev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_bswap(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN/8; i++) r[8*i +: 8] = v[XLEN-8-8*i +: 8];
    return r;
  endfunction

  assign sh = issue_rs2[SW-1:0];
  assign lt = issue_fn7[0] ? ($signed(issue_rs1) < $signed(issue_rs2))
                           : (issue_rs1 < issue_rs2);

  always_comb begin
    op_res = '0;
    case (issue_fn3)
      3'b000: op_res = issue_fn7[5]
        ? ((issue_rs1 >> sh) | (issue_rs1 << (XLEN - int'(sh))))
        : ((issue_rs1 << sh) | (issue_rs1 >> (XLEN - int'(sh))));
      3'b001: op_res = f_pop(issue_rs1);
      3'b011: op_res = f_clz(issue_rs1);
      3'b100: op_res = f_bswap(issue_rs1);
      3'b101: op_res = f_brev(issue_rs1);
      3'b110: op_res = (lt ^ issue_fn7[5]) ? issue_rs1 : issue_rs2;
      default: op_res = '0;
    endcase
  end

  assign wb_done     = (count != '0);
  assign wb_id       = wb_done ? mem_id[rp] : '0;
  assign wb_rd       = wb_done ? mem_rd[rp] : '0;
  assign pop         = wb_done & wb_ack & ~flush;
  // a same-cycle pop frees the slot, so a full FIFO can still accept
  assign issue_ready = ~rst & ~flush & idle
                     & ((count < CW'(DEPTH)) | pop);
  assign accept      = issue_valid & issue_ready;

`ifdef SP_UNIT_CRC_EN
  typedef enum logic {IDLE, CRC_BUSY} state_t;

  state_t          state, state_nx;
  logic [2:0]      cnt, cnt_nx;
  logic [31:0]     crc, crc_nx;
  logic [ID_W-1:0] crc_id, crc_id_nx;
  logic            crc_push, is_crc;

  function automatic logic [31:0] crc_bit(input logic [31:0] c);
    return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

  assign is_crc = (issue_fn3 == 3'b010);
  assign idle   = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= IDLE;
      cnt    <= '0;
      crc    <= '0;
      crc_id <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      crc    <= crc_nx;
      crc_id <= crc_id_nx;
    end
  end

  // first iteration happens on the accept edge, seven more while busy
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    crc_nx    = crc;
    crc_id_nx = crc_id;
    crc_push  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_crc) begin
          state_nx  = CRC_BUSY;
          cnt_nx    = 3'd1;
          crc_nx    = crc_bit(issue_rs1[31:0] ^ {24'b0, issue_rs2[7:0]});
          crc_id_nx = issue_id;
        end
      end
      CRC_BUSY: begin
        crc_nx = crc_bit(crc);
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) begin
          crc_push = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign push    = crc_push | (accept & ~is_crc);
  assign push_rd = crc_push ? XLEN'(crc_bit(crc)) : op_res;
  assign push_id = crc_push ? crc_id : issue_id;
  assign unused_bits = ^{issue_fn7[6], issue_fn7[4:1]};
`else
  assign idle    = 1'b1;
  assign push    = accept;
  assign push_rd = op_res;
  assign push_id = issue_id;
  assign unused_bits = ^{issue_fn7[6], issue_fn7[4:1], CRC_POLY};
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_rd[wp] <= push_rd;
      mem_id[wp] <= push_id;
    end
  end

endmodule

// File: tb/tb_sp_unit_pipe.sv
// Directed bench for sp_unit_pipe: ops, FIFO fill/wrap, flush.
// Inputs change on the falling edge; outputs are read there too.
module tb_sp_unit_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_fn3;
  logic [6:0]  issue_fn7;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [2:0]  issue_id;
  logic        flush;
  logic        wb_done;
  logic [2:0]  wb_id;
  logic [31:0] wb_rd;
  logic        wb_ack;

  int errors = 0;
  int checks = 0;

  sp_unit_pipe dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_fn3(issue_fn3), .issue_fn7(issue_fn7),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_id(issue_id), .flush(flush),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] id);
    issue_valid = 1'b1;
    issue_fn3 = f3;
    issue_fn7 = f7;
    issue_rs1 = a;
    issue_rs2 = b;
    issue_id  = id;
  endtask

  // one op into an empty FIFO; returns what the head shows next cycle
  task automatic run_op(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id,
                        output logic done, output logic [2:0] oid,
                        output logic [31:0] ord);
    drive(f3, f7, a, b, id);
    cyc();
    issue_valid = 1'b0;
    done = wb_done;
    oid  = wb_id;
    ord  = wb_rd;
    wb_ack = 1'b1;
    cyc();
    wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    wb_ack = 1'b0;
    drive(3'b001, 7'd0, 32'h1, 32'h0, 3'd1);
    @(negedge clk);
    cyc();
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", issue_ready);
    end
    rst = 1'b0;
    issue_valid = 1'b0;
    #1;
    checks++;
    if (wb_done !== 1'b0 || wb_id !== 3'd0 || wb_rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: done=%b id=%0d rd=%h want 0/0/0",
               wb_done, wb_id, wb_rd);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", issue_ready);
    end
  endtask

  task automatic test_rotate();
    logic d;
    logic [2:0] id;
    logic [31:0] rd;
    run_op(3'b000, 7'h00, 32'h8000_0001, 32'd4, 3'd2, d, id, rd);
    checks++;
    if (d !== 1'b1 || id !== 3'd2 || rd !== 32'h0000_0018) begin
      errors++;
      $display("FAIL rotl: done=%b id=%0d rd=%h want 1/2/00000018",
               d, id, rd);
    end
    run_op(3'b000, 7'h20, 32'h8000_0001, 32'd36, 3'd3, d, id, rd);
    checks++;
    if (rd !== 32'h1800_0000 || id !== 3'd3) begin
      errors++;
      $display("FAIL rotr_wrap_amt: rd=%h id=%0d want 18000000/3", rd, id);
    end
    checks++;
    if (wb_done !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: done=%b want 0", wb_done);
    end
  endtask

  task automatic test_ops();
    logic d;
    logic [2:0] id;
    logic [31:0] rd;
    logic [2:0]  f3 [8];
    logic [6:0]  f7 [8];
    logic [31:0] a  [8];
    logic [31:0] b  [8];
    logic [31:0] ex [8];
    f3 = '{3'b011, 3'b011, 3'b110, 3'b110,
           3'b110, 3'b100, 3'b101, 3'b111};
    f7 = '{7'h00, 7'h00, 7'h01, 7'h00,
           7'h21, 7'h00, 7'h00, 7'h00};
    a  = '{32'h0, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0001, 32'hDEAD_BEEF};
    b  = '{32'h0, 32'h0, 32'h1, 32'h1,
           32'h1, 32'h0, 32'h0, 32'h1234_5678};
    ex = '{32'd32, 32'd15, 32'hFFFF_FFFF, 32'h1,
           32'h1, 32'h7856_3412, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(f3[i], f7[i], a[i], b[i], 3'(i), d, id, rd);
      checks++;
      if (d !== 1'b1 || rd !== ex[i] || id !== 3'(i)) begin
        errors++;
        $display("FAIL op%0d: done=%b id=%0d rd=%h want 1/%0d/%h",
                 i, d, id, rd, i, ex[i]);
      end
    end
  endtask

`ifdef SP_UNIT_CRC_EN
  task automatic test_crc();
    drive(3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0, 3'd5);
    cyc();
    issue_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      checks++;
      if (issue_ready !== 1'b0 || wb_done !== 1'b0) begin
        errors++;
        $display("FAIL crc_busy_c%0d: ready=%b done=%b want 0/0",
                 i, issue_ready, wb_done);
      end
      cyc();
    end
    checks++;
    if (wb_done !== 1'b1 || wb_id !== 3'd5 || wb_rd !== 32'h2DFD_1072) begin
      errors++;
      $display("FAIL crc_result: done=%b id=%0d rd=%h want 1/5/2dfd1072",
               wb_done, wb_id, wb_rd);
    end
    wb_ack = 1'b1;
    cyc();
    wb_ack = 1'b0;
  endtask
`else
  task automatic test_crc();
    logic d;
    logic [2:0] id;
    logic [31:0] rd;
    run_op(3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0, 3'd5, d, id, rd);
    checks++;
    if (d !== 1'b1 || id !== 3'd5 || rd !== 32'h0) begin
      errors++;
      $display("FAIL crc_reserved: done=%b id=%0d rd=%h want 1/5/0",
               d, id, rd);
    end
  endtask
`endif

  task automatic test_fill();
    logic [31:0] a  [4];
    logic [31:0] ex [4];
    a  = '{32'h0, 32'h1, 32'h3, 32'hFFFF_FFFF};
    ex = '{32'd0, 32'd1, 32'd2, 32'd32};
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 7'h00, a[i], 32'h0, 3'(i));
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want 1", i, issue_ready);
      end
      cyc();
    end
    // a rejected issue while full must not disturb the queue
    drive(3'b001, 7'h00, 32'hFF, 32'h0, 3'd7);
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b want 0", issue_ready);
    end
    cyc();
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_done !== 1'b1 || wb_id !== 3'(i) || wb_rd !== ex[i]) begin
        errors++;
        $display("FAIL fill_pop%0d: done=%b id=%0d rd=%h want 1/%0d/%h",
                 i, wb_done, wb_id, wb_rd, i, ex[i]);
      end
      wb_ack = 1'b1;
      cyc();
      wb_ack = 1'b0;
    end
    checks++;
    if (wb_done !== 1'b0) begin
      errors++;
      $display("FAIL fill_drained: done=%b want 0", wb_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a  [4];
    logic [2:0]  eid [4];
    logic [31:0] ex  [4];
    a   = '{32'h7, 32'hF, 32'h1F, 32'h3F};
    eid = '{3'd5, 3'd6, 3'd7, 3'd0};
    ex  = '{32'd4, 32'd5, 32'd6, 32'd8};
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 7'h00, a[i], 32'h0, 3'(4 + i));
      cyc();
    end
    drive(3'b001, 7'h00, 32'hFF, 32'h0, 3'd0);
    wb_ack = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ack_ready: got %b want 1", issue_ready);
    end
    cyc();
    issue_valid = 1'b0;
    wb_ack = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL still_full: ready=%b want 0", issue_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_done !== 1'b1 || wb_id !== eid[i] || wb_rd !== ex[i]) begin
        errors++;
        $display("FAIL wrap_pop%0d: done=%b id=%0d rd=%h want 1/%0d/%h",
                 i, wb_done, wb_id, wb_rd, eid[i], ex[i]);
      end
      wb_ack = 1'b1;
      cyc();
      wb_ack = 1'b0;
    end
    checks++;
    if (wb_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drained: done=%b want 0", wb_done);
    end
  endtask

  task automatic test_flush();
    drive(3'b001, 7'h00, 32'h1, 32'h0, 3'd1);
    cyc();
    drive(3'b001, 7'h00, 32'h3, 32'h0, 3'd2);
    cyc();
`ifdef SP_UNIT_CRC_EN
    drive(3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0, 3'd3);
    cyc();
    issue_valid = 1'b0;
    cyc();
`endif
    drive(3'b001, 7'h00, 32'h7, 32'h0, 3'd4);
    flush  = 1'b1;
    wb_ack = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", issue_ready);
    end
    cyc();
    flush = 1'b0;
    wb_ack = 1'b0;
    issue_valid = 1'b0;
    #1;
    checks++;
    if (wb_done !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: done=%b ready=%b want 0/1",
               wb_done, issue_ready);
    end
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (wb_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: done=%b want 0", wb_done);
    end
  endtask

  initial begin
    issue_valid = 1'b0;
    issue_fn3 = '0;
    issue_fn7 = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_id  = '0;
    test_reset();
    test_rotate();
    test_ops();
    test_crc();
    test_fill();
    test_back_to_back();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
